// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the PC fetch sequencer: FSM state type and the default reset PC.
package pc_fetch_ctrl_pkg;

   typedef enum logic [1:0] {BOOT, RUN, HOLD, HALT} fetch_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Bundle of redirect, hazard, instruction-memory and status signals around pc_fetch_ctrl.
// The slave modport is the fetch controller's view; master is the surrounding pipeline's view.
interface pc_fetch_ctrl_if #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
);
   logic             redirect_vld;
   logic [PC_W-1:0]  redirect_pc;
   logic             stall;
   logic             halt;
   logic             imem_ready;
   logic             imem_req;
   logic [PC_W-1:0]  imem_addr;
   logic [PC_W-1:0]  pc;
   logic [PC_W-1:0]  pc_plus1;
   logic             if_flush;
   logic             halted;
   logic [CNT_W-1:0] redirect_cnt;
   logic [CNT_W-1:0] stall_cnt;

   // Fetch handshake: a fetch completes on a cycle where imem_req and imem_ready are both high
   // and stall is low; otherwise imem_req stays high with an unchanged imem_addr.
   modport slave (
      input  redirect_vld, redirect_pc, stall, halt, imem_ready,
      output imem_req, imem_addr, pc, pc_plus1, if_flush, halted, redirect_cnt, stall_cnt
   );

   modport master (
      output redirect_vld, redirect_pc, stall, halt, imem_ready,
      input  imem_req, imem_addr, pc, pc_plus1, if_flush, halted, redirect_cnt, stall_cnt
   );
endinterface

// File: rtl/pc_fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the PC_PERF_CNT_EN perf counters.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch sequencer (BOOT -> RUN <-> HOLD, any -> HALT).
// Optional perf counters are built only when PC_PERF_CNT_EN is defined.
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          PC_W     = 32,
   parameter int          CNT_W    = 32
) (
   input  logic               clk,
   input  logic               rst,
   pc_fetch_ctrl_if.slave     bus
);
   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] pend_pc_q, pend_pc_d;
   logic            pend_vld_q, pend_vld_d;
   logic            if_flush_q, if_flush_d;
   logic            advance;

   assign advance = bus.imem_ready & ~bus.stall;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_pc_d  = pend_pc_q;
      pend_vld_d = pend_vld_q;
      if_flush_d = 1'b0;
      case (state_q)
         BOOT: state_d = RUN;
         RUN, HOLD: begin
            if (bus.halt) begin
               state_d    = HALT;
               pend_vld_d = 1'b0;
            end else if (advance) begin
               // A live redirect is the newer decision and supersedes any pending target.
               if (bus.redirect_vld) begin
                  pc_d       = bus.redirect_pc;
                  if_flush_d = 1'b1;
               end else if (pend_vld_q) begin
                  pc_d       = pend_pc_q;
                  if_flush_d = 1'b1;
               end else begin
                  pc_d = pc_q + PC_W'(1);
               end
               pend_vld_d = 1'b0;
               state_d    = RUN;
            end else if (bus.redirect_vld) begin
               pend_pc_d  = bus.redirect_pc;
               pend_vld_d = 1'b1;
               state_d    = HOLD;
            end
         end
         HALT: state_d = HALT;
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BOOT;
         pc_q       <= PC_W'(RESET_PC);
         pend_pc_q  <= '0;
         pend_vld_q <= 1'b0;
         if_flush_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_pc_q  <= pend_pc_d;
         pend_vld_q <= pend_vld_d;
         if_flush_q <= if_flush_d;
      end
   end

   assign bus.imem_req  = (state_q == RUN) || (state_q == HOLD);
   assign bus.imem_addr = pc_q;
   assign bus.pc        = pc_q;
   assign bus.pc_plus1  = pc_q + PC_W'(1);
   assign bus.if_flush  = if_flush_q;
   assign bus.halted    = (state_q == HALT);

`ifdef PC_PERF_CNT_EN
   logic stall_cycle;
   assign stall_cycle = ((state_q == RUN) || (state_q == HOLD)) & ~advance;

   // if_flush_d is high exactly when a redirect (live or pending) is applied.
   sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (if_flush_d),
      .count (bus.redirect_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (stall_cycle),
      .count (bus.stall_cnt)
   );
`else
   assign bus.redirect_cnt = '0;
   assign bus.stall_cnt    = '0;
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: vector table, directed corner sequences and
// randomized traffic against a behavioural model of the fetch rules.
module tb_pc_fetch_ctrl;
   import pc_fetch_ctrl_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   pc_fetch_ctrl_if #(.PC_W(32), .CNT_W(32)) bus ();

   pc_fetch_ctrl #(.RESET_PC(32'h0), .PC_W(32), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural model: phase 0 = booting, 1 = fetching, 2 = halted
   int          m_phase;
   logic [31:0] m_pc;
   logic [31:0] m_pend[$];
   logic        m_flush;
   longint      m_rc;
   longint      m_sc;
   localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

   task automatic model_step(input logic r, rv, input logic [31:0] rpc,
                             input logic st, h, rdy);
      bit adv;
      adv = rdy && !st;
      if (r) begin
         m_phase = 0; m_pc = 32'h0; m_pend.delete(); m_flush = 0; m_rc = 0; m_sc = 0;
      end else if (m_phase == 0) begin
         m_phase = 1; m_flush = 0;
      end else if (m_phase == 1) begin
         if (!adv) m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : m_sc;
         m_flush = 0;
         if (h) begin
            m_phase = 2; m_pend.delete();
         end else if (adv) begin
            if (rv) begin
               m_pc = rpc; m_flush = 1; m_pend.delete();
            end else if (m_pend.size() > 0) begin
               m_pc = m_pend.pop_back(); m_flush = 1; m_pend.delete();
            end else begin
               m_pc = m_pc + 1;
            end
            if (m_flush) m_rc = (m_rc < CNT_MAX) ? m_rc + 1 : m_rc;
         end else if (rv) begin
            m_pend.delete(); m_pend.push_back(rpc);
         end
      end else begin
         m_flush = 0;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      chk("m_pc", bus.pc, m_pc);
      chk("m_imem_addr", bus.imem_addr, m_pc);
      chk("m_pc_plus1", bus.pc_plus1, m_pc + 32'h1);
      chk("m_imem_req", {31'b0, bus.imem_req}, {31'b0, m_phase == 1});
      chk("m_halted", {31'b0, bus.halted}, {31'b0, m_phase == 2});
      chk("m_if_flush", {31'b0, bus.if_flush}, {31'b0, m_flush});
`ifdef PC_PERF_CNT_EN
      chk("m_redirect_cnt", bus.redirect_cnt, m_rc[31:0]);
      chk("m_stall_cnt", bus.stall_cnt, m_sc[31:0]);
`else
      chk("m_redirect_cnt", bus.redirect_cnt, 32'h0);
      chk("m_stall_cnt", bus.stall_cnt, 32'h0);
`endif
   endtask

   // driver: apply one cycle of inputs, advance the model, check after the edge
   task automatic apply(input logic r, rv, input logic [31:0] rpc,
                        input logic st, h, rdy);
      rst              = r;
      bus.redirect_vld = rv;
      bus.redirect_pc  = rpc;
      bus.stall        = st;
      bus.halt         = h;
      bus.imem_ready   = rdy;
      model_step(r, rv, rpc, st, h, rdy);
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic expect_out(input string nm, input logic [31:0] pc,
                             input logic req, fl, hl);
      chk({nm, "_pc"}, bus.pc, pc);
      chk({nm, "_req"}, {31'b0, bus.imem_req}, {31'b0, req});
      chk({nm, "_flush"}, {31'b0, bus.if_flush}, {31'b0, fl});
      chk({nm, "_halted"}, {31'b0, bus.halted}, {31'b0, hl});
   endtask

   typedef struct {
      logic        r;
      logic        rv;
      logic [31:0] rpc;
      logic        st;
      logic        h;
      logic        rdy;
      logic [31:0] e_pc;
      logic        e_req;
      logic        e_flush;
      logic        e_halted;
   } vec_t;

   vec_t tbl[10];

   function automatic vec_t mk(input logic r, rv, input logic [31:0] rpc, input logic st, h, rdy,
                               input logic [31:0] e_pc, input logic e_req, e_flush, e_halted);
      vec_t v;
      v.r = r; v.rv = rv; v.rpc = rpc; v.st = st; v.h = h; v.rdy = rdy;
      v.e_pc = e_pc; v.e_req = e_req; v.e_flush = e_flush; v.e_halted = e_halted;
      return v;
   endfunction

   initial begin
      longint base;
      checks = 0;
      errors = 0;
      m_phase = 0; m_pc = 0; m_flush = 0; m_rc = 0; m_sc = 0;
      rst = 1'b1;
      bus.redirect_vld = 0; bus.redirect_pc = 0; bus.stall = 0; bus.halt = 0; bus.imem_ready = 0;

      // reset, boot, sequential fetch, then a taken redirect at pc=5
      tbl[0] = mk(1, 0, 32'h0,  0, 0, 1, 32'h0,  0, 0, 0);
      tbl[1] = mk(1, 0, 32'h0,  0, 0, 1, 32'h0,  0, 0, 0);
      tbl[2] = mk(0, 0, 32'h0,  0, 0, 1, 32'h0,  1, 0, 0);
      tbl[3] = mk(0, 0, 32'h0,  0, 0, 1, 32'h1,  1, 0, 0);
      tbl[4] = mk(0, 0, 32'h0,  0, 0, 1, 32'h2,  1, 0, 0);
      tbl[5] = mk(0, 0, 32'h0,  0, 0, 1, 32'h3,  1, 0, 0);
      tbl[6] = mk(0, 0, 32'h0,  0, 0, 1, 32'h4,  1, 0, 0);
      tbl[7] = mk(0, 0, 32'h0,  0, 0, 1, 32'h5,  1, 0, 0);
      tbl[8] = mk(0, 1, 32'h40, 0, 0, 1, 32'h40, 1, 1, 0);
      tbl[9] = mk(0, 0, 32'h0,  0, 0, 1, 32'h41, 1, 0, 0);
      for (int i = 0; i < 10; i++) begin
         apply(tbl[i].r, tbl[i].rv, tbl[i].rpc, tbl[i].st, tbl[i].h, tbl[i].rdy);
         expect_out($sformatf("tbl%0d", i), tbl[i].e_pc, tbl[i].e_req, tbl[i].e_flush, tbl[i].e_halted);
      end

      // redirects while stalled: latest target wins, the first is never fetched
      apply(0, 1, 32'h8, 0, 0, 1);  expect_out("t3_to8", 32'h8, 1, 1, 0);
      base = m_rc;
      apply(0, 1, 32'h20, 1, 0, 1); expect_out("t3_hold1", 32'h8, 1, 0, 0);
      apply(0, 1, 32'h30, 1, 0, 0); expect_out("t3_hold2", 32'h8, 1, 0, 0);
      apply(0, 0, 32'h0, 0, 0, 1);  expect_out("t3_apply", 32'h30, 1, 1, 0);
      apply(0, 0, 32'h0, 0, 0, 1);  expect_out("t3_next", 32'h31, 1, 0, 0);
`ifdef PC_PERF_CNT_EN
      chk("t3_redirect_cnt", bus.redirect_cnt, 32'(base + 1));
`else
      chk("t3_redirect_cnt", bus.redirect_cnt, 32'h0);
`endif

      // memory not ready for three cycles
      apply(0, 1, 32'h10, 0, 0, 1); expect_out("t4_to10", 32'h10, 1, 1, 0);
      base = m_sc;
      for (int i = 0; i < 3; i++) begin
         apply(0, 0, 32'h0, 0, 0, 0); expect_out($sformatf("t4_wait%0d", i), 32'h10, 1, 0, 0);
      end
`ifdef PC_PERF_CNT_EN
      chk("t4_stall_cnt", bus.stall_cnt, 32'(base + 3));
`else
      chk("t4_stall_cnt", bus.stall_cnt, 32'h0);
`endif
      apply(0, 0, 32'h0, 0, 0, 1);  expect_out("t4_adv", 32'h11, 1, 0, 0);

      // halt beats a simultaneous redirect; only rst leaves HALT
      apply(0, 1, 32'h12, 0, 0, 1); expect_out("t5_to12", 32'h12, 1, 1, 0);
      apply(0, 1, 32'h80, 0, 1, 1); expect_out("t5_halt", 32'h12, 0, 0, 1);
      apply(0, 1, 32'h90, 0, 0, 1); expect_out("t5_sticky", 32'h12, 0, 0, 1);
      apply(1, 0, 32'h0, 0, 0, 1);  expect_out("t5_rst", 32'h0, 0, 0, 0);
      apply(0, 0, 32'h0, 0, 0, 1);  expect_out("t5_run", 32'h0, 1, 0, 0);

      // wraparound, then reset in HOLD drops the pending target
      apply(0, 1, 32'hFFFF_FFFF, 0, 0, 1); expect_out("t6_top", 32'hFFFF_FFFF, 1, 1, 0);
      apply(0, 0, 32'h0, 0, 0, 1);  expect_out("t6_wrap", 32'h0, 1, 0, 0);
      apply(0, 1, 32'h55, 1, 0, 1); expect_out("t6_hold", 32'h0, 1, 0, 0);
      apply(1, 0, 32'h0, 0, 0, 1);  expect_out("t6_rst", 32'h0, 0, 0, 0);
      apply(0, 0, 32'h0, 0, 0, 1);  expect_out("t6_boot", 32'h0, 1, 0, 0);
      apply(0, 0, 32'h0, 0, 0, 1);  expect_out("t6_seq", 32'h1, 1, 0, 0);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic r, rv, st, h, rdy;
         r   = ($urandom_range(0, 99) == 0);
         rv  = ($urandom_range(0, 3) == 0);
         st  = ($urandom_range(0, 3) == 0);
         h   = ($urandom_range(0, 63) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         apply(r, rv, $urandom, st, h, rdy);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
